// File: rtl/ibus_sram_resp_pkg.sv
// Shared bus types for the femto AHB-lite SRAM responder:
// hsize/hresp encodings, responder FSM states and lane helpers.
package femto_bus_pkg;

    typedef enum logic [1:0] {
        HSIZE_BYTE = 2'd0,
        HSIZE_HALF = 2'd1,
        HSIZE_WORD = 2'd2,
        HSIZE_BAD  = 2'd3
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_e;

    function automatic logic [3:0] byte_en(hsize_e size, logic [1:0] lo);
        case (size)
            HSIZE_BYTE: return 4'b0001 << lo;
            HSIZE_HALF: return 4'b0011 << lo;
            HSIZE_WORD: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] be_mask(logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Right-justify the addressed lane(s) of a word, zeroing the rest.
    function automatic logic [31:0] rd_extract(logic [31:0] word,
                                               hsize_e size,
                                               logic [1:0] lo);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (size)
            HSIZE_BYTE: return {24'h0, sh[7:0]};
            HSIZE_HALF: return {16'h0, sh[15:0]};
            default:    return word;
        endcase
    endfunction

endpackage

// File: rtl/ibus_sram_resp_if.sv
// Simplified AHB-lite bus bundle between the femto core and a responder.
// master drives address/control/write data; slave returns data/ready/resp.
interface ibus_sram_resp_if;

    logic [31:0] haddr;
    logic        htrans;
    logic        hwrite;
    logic [1:0]  hsize;
    logic        hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hprot, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hprot, hwdata,
        output hrdata, hready, hresp
    );

endinterface

// File: rtl/ibus_sram_resp_sram.sv
// sram_1rw: DEPTH_WORDS x 32 array, synchronous read, byte-masked write.
// Ports: clk_i, re_i/raddr_i/rdata_o read side, we_i/be_i/waddr_i/wdata_i write.
module sram_1rw #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Read-first: a same-address read sees the old word; the
    // responder merges the written bytes itself.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
        for (int b = 0; b < 4; b++) begin
            if (we_i && be_i[b]) begin
                mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ibus_sram_resp.sv
// AHB-lite SRAM responder: pipelined accept, WAIT_STATES wait cycles,
// two-cycle ERROR. Ports: clk, rstn (sync, active-low), bus (slave modport).
module ibus_sram_resp
    import femto_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic           clk,
    input  logic           rstn,
    ibus_sram_resp_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          hready_q, hready_d;
    logic          hresp_q, hresp_d;

    logic          dp_valid_q;
    logic          dp_write_q;
    hsize_e        dp_size_q;
    logic [1:0]    dp_lo_q;
    logic [AW-1:0] dp_idx_q;

    logic [3:0]    fwd_be_q;
    logic [31:0]   fwd_data_q;

    hsize_e        size_in;
    logic [AW-1:0] idx_in;
    logic          oob;
    logic          legal;
    logic          accept;
    logic          done;
    logic          wr_fire;
    logic          rd_fire;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [31:0]   sram_rdata;
    logic [31:0]   fwd_mask;
    logic [31:0]   held_word;

    assign size_in = hsize_e'(bus.hsize);
    assign idx_in  = bus.haddr[AW+1:2];
    assign oob     = |bus.haddr[31:AW+2];

    always_comb begin
        legal = ~oob & ~(bus.hwrite & ~bus.hprot);
        case (size_in)
            HSIZE_BYTE: ;
            HSIZE_HALF: if (bus.haddr[0]) legal = 1'b0;
            HSIZE_WORD: if (|bus.haddr[1:0]) legal = 1'b0;
            default:    legal = 1'b0;
        endcase
    end

    // hready_q is low exactly in ERR1 and in WAIT with a nonzero count.
    assign accept  = bus.htrans & hready_q;
    assign done    = hready_q & dp_valid_q;
    assign wr_fire = done & dp_write_q & rstn;
    assign rd_fire = accept & legal & ~bus.hwrite;
    assign wr_be   = byte_en(dp_size_q, dp_lo_q);
    assign wr_data = bus.hwdata << {dp_lo_q, 3'b000};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
        unique case (state_q)
            ST_ERR1: begin
                state_d = ST_ERR2;
                hresp_d = HRESP_ERROR;
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d    = cnt_q - 4'd1;
                    hready_d = (cnt_q == 4'd1);
                end
            end
            default: ;
        endcase
        if (accept) begin
            if (!legal) begin
                state_d  = ST_ERR1;
                cnt_d    = 4'd0;
                hready_d = 1'b0;
                hresp_d  = HRESP_ERROR;
            end else if (WAIT_STATES != 0) begin
                state_d  = ST_WAIT;
                cnt_d    = 4'(WAIT_STATES);
                hready_d = 1'b0;
            end else begin
                state_d  = ST_IDLE;
                cnt_d    = 4'd0;
            end
        end else if (hready_q) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
        end
    end

    // Data-phase attributes only advance when the bus is ready.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_size_q  <= HSIZE_BYTE;
            dp_lo_q    <= 2'd0;
            dp_idx_q   <= '0;
        end else if (hready_q) begin
            dp_valid_q <= accept & legal;
            dp_write_q <= bus.hwrite;
            dp_size_q  <= size_in;
            dp_lo_q    <= bus.haddr[1:0];
            dp_idx_q   <= idx_in;
        end
    end

    // Capture bytes of a write landing on the word being read.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fwd_be_q   <= 4'd0;
            fwd_data_q <= 32'd0;
        end else if (rd_fire) begin
            fwd_be_q   <= (wr_fire && dp_idx_q == idx_in) ? wr_be : 4'd0;
            fwd_data_q <= wr_data;
        end
    end

    sram_1rw #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk_i   (clk),
        .re_i    (rd_fire),
        .raddr_i (idx_in),
        .rdata_o (sram_rdata),
        .we_i    (wr_fire),
        .be_i    (wr_be),
        .waddr_i (dp_idx_q),
        .wdata_i (wr_data)
    );

    assign fwd_mask  = be_mask(fwd_be_q);
    assign held_word = (sram_rdata & ~fwd_mask) | (fwd_data_q & fwd_mask);

    assign bus.hready = hready_q;
    assign bus.hresp  = hresp_q;
    assign bus.hrdata = (done & ~dp_write_q) ?
                        rd_extract(held_word, dp_size_q, dp_lo_q) : 32'd0;

endmodule
